// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable read-during-write,
// registered read port and a clear sequencer. Define SP_RAM_OUT_REG_EN for a second output stage.
module sp_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ce,
  input  logic                     i_we,
  input  logic [DATA_W/8-1:0]      i_be,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_clr,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_clr_done
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NUM_BE = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              clr_done_q;
  logic              acc;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // An access presented together with a clear request is dropped.
  assign acc    = (state == ST_READY) && i_ce && !i_clr;
  assign o_busy = (state == ST_CLEAR);

  always_comb begin
    merged = mem[i_addr];
    for (int k = 0; k < NUM_BE; k++) begin
      if (i_be[k]) begin
        merged[8*k +: 8] = i_data[8*k +: 8];
      end
    end
  end

  assign rd_word = (RDW_MODE != 0 && i_we) ? merged : mem[i_addr];

  // The array itself is never reset; the sweep zeroes it word by word.
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (acc && i_we) begin
      mem[i_addr] <= merged;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state      <= ST_READY;
            clr_done_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (i_clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= acc;
      if (acc) begin
        data_q <= rd_word;
      end
    end
  end

  assign o_clr_done = clr_done_q;

`ifdef SP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] data_q2;
  logic              valid_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q2  <= '0;
      valid_q2 <= 1'b0;
    end else begin
      valid_q2 <= valid_q;
      if (valid_q) begin
        data_q2 <= data_q;
      end
    end
  end

  assign o_data  = data_q2;
  assign o_valid = valid_q2;
`else
  assign o_data  = data_q;
  assign o_valid = valid_q;
`endif

endmodule

// File: tb/tb_sp_ram_param.sv
// Directed testbench for sp_ram_param: an 8-bit read-first instance and a 32-bit write-first instance.
module tb_sp_ram_param;

`ifdef SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        ce, we, clr;
  logic [0:0]  be;
  logic [5:0]  addr;
  logic [7:0]  data;
  logic [7:0]  q8;
  logic        v8, busy8, done8;

  logic        ce32, we32;
  logic [3:0]  be32;
  logic [5:0]  addr32;
  logic [31:0] data32, q32;
  logic        v32, busy32, done32;

  int checkCount = 0;
  int passCount  = 0;

  logic       opWe   [10];
  logic [5:0] opAddr [10];
  logic [7:0] opData [10];
  logic [7:0] opExp  [10];

  sp_ram_param #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0)) dut8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(ce), .i_we(we), .i_be(be),
    .i_addr(addr), .i_data(data), .i_clr(clr),
    .o_data(q8), .o_valid(v8), .o_busy(busy8), .o_clr_done(done8)
  );

  sp_ram_param #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(1)) dut32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(ce32), .i_we(we32), .i_be(be32),
    .i_addr(addr32), .i_data(data32), .i_clr(1'b0),
    .o_data(q32), .o_valid(v32), .o_busy(busy32), .o_clr_done(done32)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic cl, input logic [5:0] a,
                               input logic [7:0] d, input logic b);
    ce = c; we = w; clr = cl; addr = a; data = d; be = b;
    tick();
  endtask

  // Single isolated access on the 8-bit instance; checks the strobe, data and strobe fall.
  task automatic access8(input string tag, input logic w, input logic [5:0] a, input logic [7:0] d,
                         input logic b, input logic [7:0] expData);
    applyStimulus(1'b1, w, 1'b0, a, d, b);
    ce = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    checkOutput({tag, "_valid"}, 32'(v8), 32'd1);
    checkOutput({tag, "_data"}, 32'(q8), 32'(expData));
    tick();
    checkOutput({tag, "_strobe"}, 32'(v8), 32'd0);
  endtask

  task automatic access32(input string tag, input logic w, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] expData);
    ce32 = 1'b1; we32 = w; addr32 = a; data32 = d; be32 = b;
    tick();
    ce32 = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    checkOutput({tag, "_valid"}, 32'(v32), 32'd1);
    checkOutput({tag, "_data"}, q32, expData);
    tick();
  endtask

  task automatic sweepCount(output int cycles, output int dones, output int valids);
    cycles = 0; dones = 0; valids = 0;
    while (busy8 && cycles < 200) begin
      tick();
      cycles++;
      dones  += int'(done8);
      valids += int'(v8);
    end
  endtask

  task automatic b2bRun(input int n);
    for (int c = 0; c < n + LAT; c++) begin
      if (c < n) applyStimulus(1'b1, opWe[c], 1'b0, opAddr[c], opData[c], 1'b1);
      else       applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
      if (c - (LAT - 1) >= 0 && c - (LAT - 1) < n) begin
        checkOutput($sformatf("b2b%0d_valid", c - (LAT - 1)), 32'(v8), 32'd1);
        checkOutput($sformatf("b2b%0d_data", c - (LAT - 1)), 32'(q8), 32'(opExp[c - (LAT - 1)]));
      end else begin
        checkOutput($sformatf("b2b_idle%0d", c), 32'(v8), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cyc, dn, vl;
    ce = 0; we = 0; clr = 0; be = 0; addr = 0; data = 0;
    ce32 = 0; we32 = 0; be32 = 0; addr32 = 0; data32 = 0;

    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy8), 32'd1);
    checkOutput("rst_valid", 32'(v8), 32'd0);
    checkOutput("rst_data", 32'(q8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);

    // Initial sweep with i_ce held high: nothing may be accepted while busy.
    ce = 1'b1;
    i_rst_n = 1'b1;
    sweepCount(cyc, dn, vl);
    ce = 1'b0;
    checkOutput("init_sweep_len", 32'(cyc), 32'd64);
    checkOutput("init_sweep_done", 32'(dn), 32'd1);
    checkOutput("init_sweep_valid", 32'(vl), 32'd0);
    checkOutput("init_busy32", 32'(busy32), 32'd0);
    tick();
    checkOutput("init_done_pulse", 32'(done8), 32'd0);

    for (int a = 0; a < 64; a++) access8($sformatf("zero%0d", a), 1'b0, 6'(a), 8'h00, 1'b0, 8'h00);

    access8("wr10", 1'b1, 6'h10, 8'hA5, 1'b1, 8'h00);
    access8("rd10", 1'b0, 6'h10, 8'h00, 1'b0, 8'hA5);
    access8("rd11", 1'b0, 6'h11, 8'h00, 1'b0, 8'h00);

    access8("wr5a", 1'b1, 6'd5, 8'h3C, 1'b1, 8'h00);
    access8("wr5b_rdw", 1'b1, 6'd5, 8'hC3, 1'b1, 8'h3C);
    access8("rd5", 1'b0, 6'd5, 8'h00, 1'b0, 8'hC3);
    access8("wr5_be0", 1'b1, 6'd5, 8'h99, 1'b0, 8'hC3);
    access8("rd5_be0", 1'b0, 6'd5, 8'h00, 1'b0, 8'hC3);

    access32("w32a", 1'b1, 6'd2, 32'h11223344, 4'hF, 32'h11223344);
    access32("w32b", 1'b1, 6'd2, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD);
    access32("r32", 1'b0, 6'd2, 32'h0, 4'h0, 32'h11BB33DD);

    for (int i = 0; i < 4; i++) begin
      opWe[i] = 1'b1; opAddr[i] = 6'(i); opData[i] = 8'(8'h10 + i); opExp[i] = 8'h00;
      opWe[i+4] = 1'b0; opAddr[i+4] = 6'(i); opData[i+4] = 8'h00; opExp[i+4] = 8'(8'h10 + i);
    end
    opWe[8] = 1'b1; opAddr[8] = 6'd9; opData[8] = 8'h66; opExp[8] = 8'h00;
    opWe[9] = 1'b0; opAddr[9] = 6'd9; opData[9] = 8'h00; opExp[9] = 8'h66;
    b2bRun(10);

    access8("wr63", 1'b1, 6'd63, 8'hFF, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd1, 8'h77, 1'b1);
    ce = 1'b0; clr = 1'b0;
    checkOutput("clr_busy", 32'(busy8), 32'd1);
    checkOutput("clr_drop_valid", 32'(v8), 32'd0);
    sweepCount(cyc, dn, vl);
    checkOutput("clr_sweep_len", 32'(cyc), 32'd64);
    checkOutput("clr_sweep_done", 32'(dn), 32'd1);
    checkOutput("clr_sweep_valid", 32'(vl), 32'd0);
    access8("rd63_clr", 1'b0, 6'd63, 8'h00, 1'b0, 8'h00);
    access8("rd1_clr", 1'b0, 6'd1, 8'h00, 1'b0, 8'h00);

    access8("wr7", 1'b1, 6'd7, 8'h5A, 1'b1, 8'h00);
    access8("rd7", 1'b0, 6'd7, 8'h00, 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 8'h00, 1'b0);
    clr = 1'b0;
    repeat (19) tick();
    checkOutput("mid_busy", 32'(busy8), 32'd1);
    checkOutput("mid_hold", 32'(q8), 32'h5A);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy8), 32'd1);
    checkOutput("mid_rst_data", 32'(q8), 32'd0);
    checkOutput("mid_rst_valid", 32'(v8), 32'd0);
    tick();
    i_rst_n = 1'b1;
    sweepCount(cyc, dn, vl);
    checkOutput("rst_sweep_len", 32'(cyc), 32'd64);
    checkOutput("rst_sweep_done", 32'(dn), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
